nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 Parameter TUNE_WIDTH, 14, width of the tuning word driven to the NCO delta_phase input.
REQ-002 Parameter DWELL_WIDTH, 16, width of the per-step dwell count.
REQ-003 clk  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a sweep.
REQ-006 stop  input  1  one-cycle request to abort a sweep.
REQ-007 f_start  input  TUNE_WIDTH  first tuning word.
REQ-008 f_stop  input  TUNE_WIDTH  final (upper) tuning word.
REQ-009 f_step  input  TUNE_WIDTH  tuning-word increment per step.
REQ-010 dwell  input  DWELL_WIDTH  enabled cycles per step.
REQ-011 delta_phase  output  TUNE_WIDTH  tuning word to the NCO.
REQ-012 load  output  1  one-cycle strobe to the NCO; delta_phase is valid while load is high.
REQ-013 en  output  1  NCO accumulate enable.
REQ-014 busy  output  1  high while a sweep is in progress.
REQ-015 done  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, DWELL and FINISH.
REQ-017 In IDLE, when start=1 and stop=0: latch f_start, f_stop, f_step and dwell; set cur=f_start; go to LOAD; busy=1 from the next cycle.
REQ-018 In LOAD: load=1 and delta_phase=cur for exactly one cycle, en=0; reload the dwell counter; go to DWELL.
REQ-019 In DWELL: en=1 for max(dwell,1) cycles; dwell=0 is treated as 1.
REQ-020 At the end of DWELL: compute nxt=cur+f_step in TUNE_WIDTH+1 bits. If cur==f_stop, go to FINISH. Otherwise cur=min(nxt,f_stop) and go to LOAD.
REQ-021 Degenerate cases: if f_step==0 or f_start>=f_stop, the sweep SHALL perform exactly one LOAD/DWELL at f_start and then go to FINISH.
REQ-022 In FINISH: done=1 and busy=0 for one cycle, en=0; then go to IDLE.
REQ-023 delta_phase SHALL hold its last loaded value outside LOAD; load SHALL never be high in the same cycle as en.
REQ-024 stop=1 in any non-IDLE state SHALL force IDLE on the next edge with en=0, load=0, busy=0 and no done pulse; stop beats start in the same cycle.
REQ-025 start while busy SHALL be ignored; config input changes during a sweep SHALL have no effect.
REQ-026 Timing per step is 1+max(dwell,1) cycles. The first load is high in the cycle after start is sampled.

Reset
REQ-027 Asserting rst SHALL immediately force: state=IDLE; delta_phase=0; load=0; en=0; busy=0; done=0; cur=0; dwell counter=0.
REQ-028 Reset mid-sweep SHALL abandon the sweep; after release the block SHALL idle until a new start.

Configuration
REQ-029 Macro NCO_SWEEP_TRIANGLE_EN: when defined, a direction bit is added. At f_stop the sweep SHALL reverse and step down by f_step, clamped at f_start. At f_start it SHALL reverse up again, repeating until stop. FINISH is then never reached and done never pulses; the apex words f_stop and f_start are each loaded once per turn.
REQ-030 Without NCO_SWEEP_TRIANGLE_EN: single up-sweep only, as in REQ-016..REQ-026, and no direction logic.

Structure
REQ-031 The shared package nco_pkg SHALL hold the sweep state enum and the default TUNE_WIDTH/DWELL_WIDTH constants.
REQ-032 The dwell down-counter SHALL be a sub-module, nco_dwell_cnt, with inputs reload and value and output expired.

Verification
REQ-033 f_start=100, f_stop=400, f_step=100, dwell=3 -> loads 100,200,300,400; 3 en cycles after each; done in cycle 17 after start; busy high cycles 1-16.
REQ-034 f_start=100, f_stop=350, f_step=100, dwell=1 -> loads 100,200,300,350 (clamped); then done.
REQ-035 TUNE_WIDTH=14, f_start=16000, f_stop=16383, f_step=300, dwell=2 -> loads 16000,16300,16383; no wrap to a small value.
REQ-036 f_step=0 or f_start=500>f_stop=400, dwell=0 -> single load 500 (or f_start), 1 en cycle, then done.
REQ-037 stop asserted in the 2nd DWELL cycle of step 2 -> en=0 and busy=0 next cycle, no done; rst asserted mid-DWELL -> all outputs 0 immediately.
REQ-038 With NCO_SWEEP_TRIANGLE_EN, f_start=100, f_stop=300, f_step=100, dwell=1 -> loads 100,200,300,200,100,200,... until stop; done never pulses.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller: sweep FSM states and default widths.
// Pure declarations; no logic, no latency, no flow control.
package nco_pkg;

    localparam int NCO_TUNE_WIDTH  = 14;
    localparam int NCO_DWELL_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DWELL  = 2'd2,
        ST_FINISH = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/nco_dwell_cnt.sv
// Dwell down-counter: reload loads a non-zero count, each decrement cycle counts down.
// Zero latency on o_expired (flags the last enabled cycle); no backpressure.
module nco_dwell_cnt
    import nco_pkg::*;
#(
    parameter int WIDTH = NCO_DWELL_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_reload,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_reload) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_expired = i_dec && (r_cnt == ONE);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Tuning-word sweep controller for an NCO: one load cycle then max(dwell,1) enable cycles per step.
// First load one cycle after start; stop aborts on the next edge; NCO_SWEEP_TRIANGLE_EN adds up/down sweeping.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int TUNE_WIDTH  = NCO_TUNE_WIDTH,
    parameter int DWELL_WIDTH = NCO_DWELL_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [TUNE_WIDTH-1:0]  i_f_start,
    input  logic [TUNE_WIDTH-1:0]  i_f_stop,
    input  logic [TUNE_WIDTH-1:0]  i_f_step,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    output logic [TUNE_WIDTH-1:0]  o_delta_phase,
    output logic                   o_load,
    output logic                   o_en,
    output logic                   o_busy,
    output logic                   o_done
);

    sweep_state_t r_state, w_state_nxt;

    logic [TUNE_WIDTH-1:0]  r_cur;
    logic [TUNE_WIDTH-1:0]  r_dp;
    logic [TUNE_WIDTH-1:0]  r_f_stop;
    logic [TUNE_WIDTH-1:0]  r_f_step;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic                   r_degen;

    logic                   w_accept;
    logic                   w_advance;
    logic                   w_expired;
    logic [TUNE_WIDTH-1:0]  w_cur_nxt;
    logic [TUNE_WIDTH:0]    w_nxt_up;
    logic [TUNE_WIDTH-1:0]  w_cur_up;
    logic [DWELL_WIDTH-1:0] w_dwell_eff;

`ifdef NCO_SWEEP_TRIANGLE_EN
    logic [TUNE_WIDTH-1:0]  r_f_start;
    logic                   r_dir_up;
    logic                   w_dir_nxt;
    logic [TUNE_WIDTH:0]    w_nxt_dn;
    logic [TUNE_WIDTH-1:0]  w_cur_dn;

    // Borrow out of the extra bit means the step went below zero.
    assign w_nxt_dn = {1'b0, r_cur} - {1'b0, r_f_step};
    assign w_cur_dn = (w_nxt_dn[TUNE_WIDTH] || (w_nxt_dn[TUNE_WIDTH-1:0] < r_f_start))
                      ? r_f_start : w_nxt_dn[TUNE_WIDTH-1:0];
`endif

    // One guard bit keeps the sum from wrapping before the clamp to f_stop.
    assign w_nxt_up    = {1'b0, r_cur} + {1'b0, r_f_step};
    assign w_cur_up    = (w_nxt_up > {1'b0, r_f_stop}) ? r_f_stop : w_nxt_up[TUNE_WIDTH-1:0];
    assign w_dwell_eff = (r_dwell == '0) ? DWELL_WIDTH'(1) : r_dwell;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_cur_nxt   = r_cur;
`ifdef NCO_SWEEP_TRIANGLE_EN
        w_dir_nxt   = r_dir_up;
`endif
        o_load      = 1'b0;
        o_en        = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_load      = 1'b1;
                o_busy      = 1'b1;
                w_state_nxt = ST_DWELL;
            end
            ST_DWELL: begin
                o_en   = 1'b1;
                o_busy = 1'b1;
                if (w_expired) begin
                    if (r_degen) begin
                        w_state_nxt = ST_FINISH;
`ifdef NCO_SWEEP_TRIANGLE_EN
                    end else begin
                        w_state_nxt = ST_LOAD;
                        w_advance   = 1'b1;
                        if (r_dir_up && (r_cur == r_f_stop)) begin
                            w_dir_nxt = 1'b0;
                            w_cur_nxt = w_cur_dn;
                        end else if (!r_dir_up && (r_cur == r_f_start)) begin
                            w_dir_nxt = 1'b1;
                            w_cur_nxt = w_cur_up;
                        end else begin
                            w_cur_nxt = r_dir_up ? w_cur_up : w_cur_dn;
                        end
                    end
`else
                    end else if (r_cur == r_f_stop) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_LOAD;
                        w_advance   = 1'b1;
                        w_cur_nxt   = w_cur_up;
                    end
`endif
                end
            end
            ST_FINISH: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (i_stop && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_advance   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur    <= '0;
            r_dp     <= '0;
            r_f_stop <= '0;
            r_f_step <= '0;
            r_dwell  <= '0;
            r_degen  <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
            r_f_start <= '0;
            r_dir_up  <= 1'b1;
`endif
        end else begin
            if (w_accept) begin
                r_cur    <= i_f_start;
                r_f_stop <= i_f_stop;
                r_f_step <= i_f_step;
                r_dwell  <= i_dwell;
                r_degen  <= (i_f_step == '0) || (i_f_start >= i_f_stop);
`ifdef NCO_SWEEP_TRIANGLE_EN
                r_f_start <= i_f_start;
                r_dir_up  <= 1'b1;
`endif
            end
            if (r_state == ST_LOAD) begin
                r_dp <= r_cur;
            end
            if (w_advance) begin
                r_cur <= w_cur_nxt;
`ifdef NCO_SWEEP_TRIANGLE_EN
                r_dir_up <= w_dir_nxt;
`endif
            end
        end
    end

    // Live word during LOAD, last loaded word at all other times.
    assign o_delta_phase = (r_state == ST_LOAD) ? r_cur : r_dp;

    logic w_cnt_reload;
    logic w_cnt_dec;
    assign w_cnt_reload = (r_state == ST_LOAD);
    assign w_cnt_dec    = (r_state == ST_DWELL);

    nco_dwell_cnt #(
        .WIDTH(DWELL_WIDTH)
    ) u_dwell_cnt (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_reload  (w_cnt_reload),
        .i_dec     (w_cnt_dec),
        .i_value   (w_dwell_eff),
        .o_expired (w_expired)
    );

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: inputs change and outputs are sampled on the falling clock edge.
module tb_nco_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [13:0] f_start;
    logic [13:0] f_stop;
    logic [13:0] f_step;
    logic [15:0] dwell;
    logic [13:0] delta_phase;
    logic        load;
    logic        en;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_mis = 0;

    int ld_q[$];
    int en_q[$];
    int exp_ld[8];
    int done_cyc;
    int busy_cnt;
    int busy_first;
    int ovl;

    nco_sweep_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_stop        (stop),
        .i_f_start     (f_start),
        .i_f_stop      (f_stop),
        .i_f_step      (f_step),
        .i_dwell       (dwell),
        .o_delta_phase (delta_phase),
        .o_load        (load),
        .o_en          (en),
        .o_busy        (busy),
        .o_done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cfg(input int a, input int b, input int c, input int d);
        f_start = 14'(a);
        f_stop  = 14'(b);
        f_step  = 14'(c);
        dwell   = 16'(d);
    endtask

    // Pulses start, then scrambles config and re-pulses start mid-sweep; both must be ignored.
    task automatic sweep(input int budget);
        ld_q.delete();
        en_q.delete();
        done_cyc   = -1;
        busy_cnt   = 0;
        busy_first = -1;
        ovl        = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg(7, 13, 1, 9);
        for (int c = 1; c <= budget; c++) begin
            if (load) begin
                ld_q.push_back(int'(delta_phase));
                en_q.push_back(0);
            end
            if (en && (en_q.size() > 0)) en_q[en_q.size()-1] += 1;
            if (load && en) ovl++;
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_cnt++;
            end
            start = (c == 3);
            if (done) begin
                done_cyc = c;
                start    = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_sweep(input string t, input int n, input int en_exp, input int done_exp);
        chk({t, "_nloads"}, ld_q.size(), n);
        for (int i = 0; (i < n) && (i < ld_q.size()); i++)
            chk($sformatf("%s_load%0d", t, i), ld_q[i], exp_ld[i]);
        for (int i = 0; i < en_q.size(); i++)
            chk($sformatf("%s_en%0d", t, i), en_q[i], en_exp);
        chk({t, "_done_cycle"}, done_cyc, done_exp);
        chk({t, "_busy_cycles"}, busy_cnt, done_exp - 1);
        chk({t, "_busy_first"}, busy_first, 1);
        chk({t, "_load_en_overlap"}, ovl, 0);
        @(negedge clk);
        chk({t, "_idle_busy"}, int'(busy), 0);
        chk({t, "_idle_done"}, int'(done), 0);
    endtask

    initial begin
        int n_done;
        int n_busy;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cfg(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_load", int'(load), 0);
        chk("rst_en", int'(en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dphase", int'(delta_phase), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

`ifdef NCO_SWEEP_TRIANGLE_EN
        cfg(100, 300, 100, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ld_q.delete();
        n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            if (load) ld_q.push_back(int'(delta_phase));
            if (done) n_done++;
            @(negedge clk);
        end
        exp_ld = '{100, 200, 300, 200, 100, 200, 0, 0};
        chk("tri_nloads", ld_q.size(), 6);
        for (int i = 0; (i < 6) && (i < ld_q.size()); i++)
            chk($sformatf("tri_load%0d", i), ld_q[i], exp_ld[i]);
        chk("tri_no_done", n_done, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("tri_stop_busy", int'(busy), 0);
        chk("tri_stop_done", int'(done), 0);
`else
        cfg(100, 400, 100, 3);
        exp_ld = '{100, 200, 300, 400, 0, 0, 0, 0};
        sweep(40);
        check_sweep("basic", 4, 3, 17);

        cfg(100, 350, 100, 1);
        exp_ld = '{100, 200, 300, 350, 0, 0, 0, 0};
        sweep(40);
        check_sweep("clamp", 4, 1, 9);

        cfg(16000, 16383, 300, 2);
        exp_ld = '{16000, 16300, 16383, 0, 0, 0, 0, 0};
        sweep(40);
        check_sweep("top", 3, 2, 10);

        cfg(100, 400, 0, 0);
        exp_ld = '{100, 0, 0, 0, 0, 0, 0, 0};
        sweep(40);
        check_sweep("step0", 1, 1, 3);

        cfg(500, 400, 100, 0);
        exp_ld = '{500, 0, 0, 0, 0, 0, 0, 0};
        sweep(40);
        check_sweep("inverted", 1, 1, 3);

        // Abort in the second dwell cycle of the second step (cycle 7).
        cfg(100, 400, 100, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("stop_pre_en", int'(en), 1);
        chk("stop_pre_dphase", int'(delta_phase), 200);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_en", int'(en), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_load", int'(load), 0);
        chk("stop_done", int'(done), 0);
        n_done = 0;
        n_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("stop_no_done", n_done, 0);
        chk("stop_stays_idle", n_busy, 0);

        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("stop_beats_start_busy", int'(busy), 0);
        chk("stop_beats_start_load", int'(load), 0);
`endif

        cfg(100, 400, 100, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rstmid_pre_en", int'(en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_en", int'(en), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_load", int'(load), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_dphase", int'(delta_phase), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) n_busy++;
        end
        chk("rstmid_idle", n_busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_load", int'(load), 1);
        chk("restart_dphase", int'(delta_phase), 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
